com_bus_arbiter_nested: RTL and testbench
=========================================

Name: com_bus_arbiter_nested

Overview:
- Parametrised successor to the fixed 8-requester common-bus arbiter in the MESI multi-core cache subsystem. It arbitrates processor-side bus requests from DL/IL caches (2*CORES requesters).
- While a processor transaction owns the bus, it grants nested snoop requests and the lower-level-memory snoop request.
- It adds selectable round-robin/fixed priority, a hold-timeout watchdog and self-snoop error detection.

Parameters:
- NUM_REQ, 8, number of requesters (2*CORES); any value 2..16.
- RR_MODE, 1, 1 = round-robin proc arbitration; 0 = fixed priority, lowest index wins.
- MAX_HOLD, 0, proc grant hold limit in cycles; 0 = unlimited.
- ID_W, 4, width of bus_owner; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Com_Bus_Req_proc  in  NUM_REQ  processor-side bus request, one bit per requester.
- Com_Bus_Req_snoop  in  NUM_REQ  snoop-side bus request.
- Mem_snoop_req  in  1  lower-level memory request to drive the bus.
- Com_Bus_Gnt_proc  out  NUM_REQ  one-hot (or zero) proc grant.
- Com_Bus_Gnt_snoop  out  NUM_REQ  one-hot (or zero) snoop grant.
- Mem_snoop_gnt  out  1  memory grant.
- bus_busy  out  1  high while any proc grant is held.
- bus_owner  out  ID_W  index of the current proc owner; 0 when idle.
- hold_timeout  out  1  one-cycle pulse when a grant is revoked by the watchdog.
- protocol_err  out  1  sticky self-snoop error flag.

Behaviour:
- Reset (async assert, sync deassert by the user): all grants, bus_busy, bus_owner, hold_timeout and protocol_err = 0. RR pointer = 0; hold counter = 0; mask register = 0.
- FSM states: IDLE, OWN, NEST_SNOOP, NEST_MEM.
- IDLE -> OWN: when any unmasked proc request is high, the winner's Com_Bus_Gnt_proc rises at the next edge (1-cycle latency). bus_busy and bus_owner update on the same edge.
- Winner selection, RR_MODE=1: first requester at or after the pointer, wrapping NUM_REQ-1 -> 0. The pointer is set to winner+1 (mod NUM_REQ) when the grant issues.
- Winner selection, RR_MODE=0: lowest index wins.
- OWN -> NEST_SNOOP: any Com_Bus_Req_snoop[j] with j != owner is high. The lowest such j is granted at the next edge. Com_Bus_Gnt_proc stays high.
- OWN -> NEST_MEM: Mem_snoop_req is high and no eligible snoop request exists. Snoops always beat memory in the same cycle.
- NEST_SNOOP/NEST_MEM -> OWN: the nested grant drops the edge after its request drops. Another nested grant can issue no earlier than the following edge, so there is one OWN cycle between nested grants.
- Proc release: when the owner's request is low in OWN, the grant drops at the next edge.
  - If other unmasked requests are pending, the new winner's grant rises on that same edge (back-to-back, no idle cycle). Otherwise go to IDLE.
  - If the owner drops its request while a nested grant is active, the proc grant is held until the nested grant releases. It then drops together with the return to OWN-exit processing.
- Self-snoop: Com_Bus_Req_snoop[owner] high while the owner holds the proc grant is ignored (never granted) and sets protocol_err, which stays set until reset.
- Snoop or memory requests while no proc owner exists are ignored; no error is raised.
- Watchdog (MAX_HOLD>0):
  - The counter clears on each new proc grant and increments each cycle in OWN only. It freezes during nested states.
  - When the counter reaches MAX_HOLD in OWN, the proc grant drops at the next edge and hold_timeout pulses for 1 cycle.
  - The owner's bit is set in the mask. A masked requester is ineligible until its request is seen low, which clears its mask bit.
  - Re-arbitration follows normal release rules.
- Invariants: at most one proc grant; at most one of {any snoop grant, Mem_snoop_gnt}; no snoop or memory grant without a proc grant.
- Reset mid-transaction: all grants drop immediately (asynchronously). No pending state survives.

Test Plan:
- RR_MODE=1: hold Com_Bus_Req_proc=8'hFF, each requester releases 2 cycles after its grant -> grant order 0,1,2,…,7,0 with back-to-back handoff and bus_owner tracking.
- RR_MODE=0, reqs {3,5} high: 3 granted. Release 3 while 1 rises -> 1 granted before 5.
- Owner 2; Com_Bus_Req_snoop=8'b0001_0001 and Mem_snoop_req=1 together -> snoop 0 granted first, then snoop 4 after a 1-cycle OWN gap, then Mem_snoop_gnt. Proc grant 2 stays high throughout.
- Owner 6 drops its request while snoop 1 is granted -> Com_Bus_Gnt_proc[6] stays high until the cycle after snoop 1 releases.
- MAX_HOLD=4, requester 0 holds its request, requester 1 pending -> grant 0 revoked after 4 OWN cycles, hold_timeout pulses, 1 granted. Requester 0 is not re-granted until it toggles low.
- Owner 3 asserts Com_Bus_Req_snoop[3] -> no snoop grant, protocol_err=1 sticky. Assert rst_n=0 mid-grant -> all outputs 0 immediately.

Source files
------------

// File: rtl/com_bus_arbiter_nested.sv
// Common-bus arbiter: processor-side ownership with nested snoop/memory grants,
// round-robin or fixed-priority selection, hold watchdog and self-snoop detection.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_IDLE       | no processor owner; snoop/memory requests ignored
// S_OWN        | proc owner holds the bus; nested requests evaluated here
// S_NEST_SNOOP | owner holds bus, one snoop requester granted on top
// S_NEST_MEM   | owner holds bus, lower-level memory granted on top
module com_bus_arbiter_nested #(
  parameter int NUM_REQ  = 8,
  parameter int RR_MODE  = 1,
  parameter int MAX_HOLD = 0,
  parameter int ID_W     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REQ-1:0]  Com_Bus_Req_proc,
  input  logic [NUM_REQ-1:0]  Com_Bus_Req_snoop,
  input  logic                Mem_snoop_req,
  output logic [NUM_REQ-1:0]  Com_Bus_Gnt_proc,
  output logic [NUM_REQ-1:0]  Com_Bus_Gnt_snoop,
  output logic                Mem_snoop_gnt,
  output logic                bus_busy,
  output logic [ID_W-1:0]     bus_owner,
  output logic                hold_timeout,
  output logic                protocol_err
);

  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam bit WD_EN = (MAX_HOLD > 0);
  localparam logic [CNT_W-1:0] CNT_LOAD = WD_EN ? CNT_W'(MAX_HOLD - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_OWN        = 2'd1,
    S_NEST_SNOOP = 2'd2,
    S_NEST_MEM   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  snp_q, snp_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  mask_q, mask_d;
  logic                err_q, err_d;
  logic                to_q, to_d;

  logic [NUM_REQ-1:0]  own_oh;
  logic                owner_req;
  logic [NUM_REQ-1:0]  snoop_other;
  logic [NUM_REQ-1:0]  snoop_pick;
  logic [NUM_REQ-1:0]  arb_vec;
  logic [ID_W:0]       win;
  logic                win_vld;
  logic [ID_W-1:0]     win_idx;
  logic [ID_W-1:0]     win_next;
  logic                do_release;
  logic                do_grant;

  // Round-robin takes the first request at or above the pointer, otherwise
  // wraps to the lowest request; fixed priority is the wrap path alone.
  function automatic logic [ID_W:0] pick_winner(input logic [NUM_REQ-1:0] v,
                                                 input logic [ID_W-1:0]    p);
    logic [ID_W:0] hi;
    logic [ID_W:0] lo;
    hi = '0;
    lo = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        lo = {1'b1, ID_W'(i)};
        if (RR_MODE != 0 && ID_W'(i) >= p) hi = {1'b1, ID_W'(i)};
      end
    end
    return hi[ID_W] ? hi : lo;
  endfunction

  assign own_oh      = NUM_REQ'(1) << owner_q;
  assign owner_req   = |(Com_Bus_Req_proc & own_oh);
  assign snoop_other = Com_Bus_Req_snoop & ~own_oh;
  assign snoop_pick  = snoop_other & (~snoop_other + NUM_REQ'(1));

  // Outside IDLE the candidate set is for a hand-off, so the owner is excluded.
  assign arb_vec  = (state_q == S_IDLE) ? (Com_Bus_Req_proc & ~mask_q)
                                        : (Com_Bus_Req_proc & ~mask_q & ~own_oh);
  assign win      = pick_winner(arb_vec, ptr_q);
  assign win_vld  = win[ID_W];
  assign win_idx  = win[ID_W-1:0];
  assign win_next = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    snp_d      = snp_q;
    cnt_d      = cnt_q;
    mask_d     = mask_q & Com_Bus_Req_proc;
    to_d       = 1'b0;
    err_d      = err_q | ((state_q != S_IDLE) && (|(Com_Bus_Req_snoop & own_oh)));
    do_release = 1'b0;
    do_grant   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (win_vld) do_grant = 1'b1;
      end
      S_OWN: begin
        if (!owner_req) begin
          do_release = 1'b1;
        end else if (WD_EN && cnt_q == '0) begin
          do_release = 1'b1;
          to_d       = 1'b1;
          mask_d     = mask_d | own_oh;
        end else begin
          if (WD_EN) cnt_d = cnt_q - 1'b1;
          if (|snoop_other) begin
            state_d = S_NEST_SNOOP;
            snp_d   = snoop_pick;
          end else if (Mem_snoop_req) begin
            state_d = S_NEST_MEM;
          end
        end
      end
      S_NEST_SNOOP: begin
        if (!(|(Com_Bus_Req_snoop & snp_q))) begin
          state_d = S_OWN;
          snp_d   = '0;
        end
      end
      S_NEST_MEM: begin
        if (!Mem_snoop_req) state_d = S_OWN;
      end
      default: state_d = S_IDLE;
    endcase

    if (do_release) begin
      if (win_vld) begin
        do_grant = 1'b1;
      end else begin
        state_d = S_IDLE;
        owner_d = '0;
      end
    end

    if (do_grant) begin
      state_d = S_OWN;
      owner_d = win_idx;
      ptr_d   = win_next;
      cnt_d   = CNT_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      snp_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      snp_q   <= snp_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

  assign Com_Bus_Gnt_proc  = (state_q != S_IDLE) ? own_oh : '0;
  assign Com_Bus_Gnt_snoop = (state_q == S_NEST_SNOOP) ? snp_q : '0;
  assign Mem_snoop_gnt     = (state_q == S_NEST_MEM);
  assign bus_busy          = (state_q != S_IDLE);
  assign bus_owner         = owner_q;
  assign hold_timeout      = to_q;
  assign protocol_err      = err_q;

endmodule

// File: tb/tb_com_bus_arbiter_nested.sv
// Bench for com_bus_arbiter_nested: three configurations (RR, fixed priority,
// RR with 4-cycle watchdog) driven in parallel and checked against a cycle model.
module tb_com_bus_arbiter_nested;
  localparam int N    = 8;
  localparam int NCFG = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req_proc = '0;
  logic [N-1:0] req_snoop = '0;
  logic         mem_req = 1'b0;

  logic [N-1:0] gp   [NCFG];
  logic [N-1:0] gs   [NCFG];
  logic         mg   [NCFG];
  logic         busy [NCFG];
  logic [3:0]   own  [NCFG];
  logic         to   [NCFG];
  logic         err  [NCFG];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    com_bus_arbiter_nested #(
      .NUM_REQ (N),
      .RR_MODE ((g == 1) ? 0 : 1),
      .MAX_HOLD((g == 2) ? 4 : 0),
      .ID_W    (4)
    ) u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .Com_Bus_Req_proc (req_proc),
      .Com_Bus_Req_snoop(req_snoop),
      .Mem_snoop_req    (mem_req),
      .Com_Bus_Gnt_proc (gp[g]),
      .Com_Bus_Gnt_snoop(gs[g]),
      .Mem_snoop_gnt    (mg[g]),
      .bus_busy         (busy[g]),
      .bus_owner        (own[g]),
      .hold_timeout     (to[g]),
      .protocol_err     (err[g])
    );
  end

  // Reference model: owner index (-1 = none), nested kind (0 none, 1 snoop, 2 mem)
  int       m_own  [NCFG];
  int       m_nest [NCFG];
  int       m_snp  [NCFG];
  int       m_ptr  [NCFG];
  int       m_held [NCFG];
  bit [7:0] m_mask [NCFG];
  bit       m_err  [NCFG];
  bit       m_to   [NCFG];

  function automatic int cfg_rr(int c);
    return (c == 1) ? 0 : 1;
  endfunction

  function automatic int cfg_mh(int c);
    return (c == 2) ? 4 : 0;
  endfunction

  function automatic int mpick(logic [7:0] v, int ptr, int rr);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (rr != 0) ? (ptr + k) % N : k;
      if (v[idx[2:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCFG; c++) begin
      m_own[c] = -1; m_nest[c] = 0; m_snp[c] = 0; m_ptr[c] = 0;
      m_held[c] = 0; m_mask[c] = '0; m_err[c] = 0; m_to[c] = 0;
    end
  endtask

  task automatic m_grant(int c, int w);
    m_own[c]  = w;
    m_ptr[c]  = (w + 1) % N;
    m_held[c] = 0;
    m_nest[c] = 0;
  endtask

  task automatic m_handoff(int c, logic [7:0] old_mask);
    int w;
    w = mpick(req_proc & ~old_mask & ~(8'(1) << m_own[c]), m_ptr[c], cfg_rr(c));
    if (w >= 0) m_grant(c, w);
    else begin
      m_own[c]  = -1;
      m_nest[c] = 0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < NCFG; c++) begin
      logic [7:0] old_mask;
      logic [7:0] others;
      int o;
      int s;
      int w;
      old_mask = m_mask[c];
      o        = m_own[c];
      s        = m_snp[c];
      m_to[c]  = 0;
      if (o >= 0 && req_snoop[o[2:0]]) m_err[c] = 1;
      m_mask[c] = old_mask & req_proc;
      if (o < 0) begin
        w = mpick(req_proc & ~old_mask, m_ptr[c], cfg_rr(c));
        if (w >= 0) m_grant(c, w);
      end else if (m_nest[c] == 1) begin
        if (!req_snoop[s[2:0]]) m_nest[c] = 0;
      end else if (m_nest[c] == 2) begin
        if (!mem_req) m_nest[c] = 0;
      end else if (!req_proc[o[2:0]]) begin
        m_handoff(c, old_mask);
      end else begin
        m_held[c]++;
        others = req_snoop & ~(8'(1) << o);
        if (cfg_mh(c) > 0 && m_held[c] >= cfg_mh(c)) begin
          m_to[c]   = 1;
          m_mask[c] = m_mask[c] | (8'(1) << o);
          m_handoff(c, old_mask);
        end else if (others != 0) begin
          m_nest[c] = 1;
          for (int j = N - 1; j >= 0; j--) if (others[j]) m_snp[c] = j;
        end else if (mem_req) begin
          m_nest[c] = 2;
        end
      end
    end
  endtask

  function automatic logic [23:0] dut_vec(int c);
    return {gp[c], gs[c], mg[c], busy[c], own[c], to[c], err[c]};
  endfunction

  function automatic logic [23:0] mdl_vec(int c);
    logic [7:0] p;
    logic [7:0] s;
    logic [3:0] ow;
    p  = (m_own[c] >= 0) ? (8'(1) << m_own[c]) : 8'h00;
    s  = (m_nest[c] == 1) ? (8'(1) << m_snp[c]) : 8'h00;
    ow = (m_own[c] >= 0) ? 4'(m_own[c]) : 4'd0;
    return {p, s, m_nest[c] == 2, m_own[c] >= 0, ow, m_to[c], m_err[c]};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_model(string tag);
    for (int c = 0; c < NCFG; c++)
      chk($sformatf("%s_cfg%0d", tag, c), 32'(dut_vec(c)), 32'(mdl_vec(c)));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    #1;
    chk_model("model");
  endtask

  task automatic do_reset();
    req_proc  = '0;
    req_snoop = '0;
    mem_req   = 1'b0;
    rst_n     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_model("reset");
    chk("reset_rr_zero", 32'(dut_vec(0)), 32'h0);
    rst_n = 1'b1;
  endtask

  task automatic async_reset_check();
    #3;
    rst_n = 1'b0;
    #1;
    for (int c = 0; c < NCFG; c++)
      chk($sformatf("async_rst_cfg%0d", c), 32'(dut_vec(c)), 32'h0);
    do_reset();
  endtask

  typedef struct {
    logic [7:0] rp;
    logic [7:0] rs;
    logic       mr;
    logic [7:0] egp;
    logic [7:0] egs;
    logic       emg;
    logic [3:0] eown;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Owner 2 with snoops 0 and 4 plus memory all pending
    tbl[0] = '{8'h04, 8'h00, 1'b0, 8'h04, 8'h00, 1'b0, 4'd2};
    tbl[1] = '{8'h04, 8'h11, 1'b1, 8'h04, 8'h01, 1'b0, 4'd2};
    tbl[2] = '{8'h04, 8'h11, 1'b1, 8'h04, 8'h01, 1'b0, 4'd2};
    tbl[3] = '{8'h04, 8'h10, 1'b1, 8'h04, 8'h00, 1'b0, 4'd2};
    tbl[4] = '{8'h04, 8'h10, 1'b1, 8'h04, 8'h10, 1'b0, 4'd2};
    tbl[5] = '{8'h04, 8'h00, 1'b1, 8'h04, 8'h00, 1'b0, 4'd2};
    tbl[6] = '{8'h04, 8'h00, 1'b1, 8'h04, 8'h00, 1'b1, 4'd2};
    tbl[7] = '{8'h04, 8'h00, 1'b0, 8'h04, 8'h00, 1'b0, 4'd2};
    tbl[8] = '{8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0};

    model_reset();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      req_proc  = tbl[i].rp;
      req_snoop = tbl[i].rs;
      mem_req   = tbl[i].mr;
      step();
      chk($sformatf("tbl%0d_gnt_proc", i), 32'(gp[0]), 32'(tbl[i].egp));
      chk($sformatf("tbl%0d_gnt_snoop", i), 32'(gs[0]), 32'(tbl[i].egs));
      chk($sformatf("tbl%0d_mem_gnt", i), 32'(mg[0]), 32'(tbl[i].emg));
      chk($sformatf("tbl%0d_owner", i), 32'(own[0]), 32'(tbl[i].eown));
    end

    // Round-robin rotation with back-to-back hand-off
    do_reset();
    req_proc = 8'hFF;
    step();
    chk("rr_first_owner", 32'(own[0]), 32'd0);
    for (int n = 1; n <= 8; n++) begin
      step();
      step();
      req_proc = 8'hFF & ~(8'(1) << ((n - 1) % N));
      step();
      chk($sformatf("rr_gnt_%0d", n), 32'(gp[0]), 32'(8'(1) << (n % N)));
      chk($sformatf("rr_owner_%0d", n), 32'(own[0]), 32'(n % N));
      req_proc = 8'hFF;
    end

    // Fixed priority: lowest index wins, late arrival 1 beats pending 5
    do_reset();
    req_proc = 8'h28;
    step();
    chk("fp_first", 32'(gp[1]), 32'h08);
    req_proc = 8'h22;
    step();
    chk("fp_second", 32'(gp[1]), 32'h02);
    chk("fp_second_owner", 32'(own[1]), 32'd1);
    req_proc = 8'h20;
    step();
    chk("fp_third", 32'(gp[1]), 32'h20);

    // Owner drops while nested snoop active: proc grant held one extra cycle
    do_reset();
    req_proc = 8'h40;
    step();
    chk("hold_owner6", 32'(gp[0]), 32'h40);
    req_snoop = 8'h02;
    step();
    chk("hold_snoop1", 32'(gs[0]), 32'h02);
    req_proc = 8'h00;
    step();
    chk("hold_nested_gp", 32'(gp[0]), 32'h40);
    chk("hold_nested_gs", 32'(gs[0]), 32'h02);
    req_snoop = 8'h00;
    step();
    chk("hold_after_snoop_gs", 32'(gs[0]), 32'h00);
    chk("hold_after_snoop_gp", 32'(gp[0]), 32'h40);
    step();
    chk("hold_released_gp", 32'(gp[0]), 32'h00);
    chk("hold_released_busy", 32'(busy[0]), 32'h0);

    // Watchdog revokes after 4 OWN cycles and masks the offender
    do_reset();
    req_proc = 8'h03;
    step();
    chk("wd_grant0", 32'(gp[2]), 32'h01);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("wd_held_%0d", k), 32'(gp[2]), 32'h01);
      chk($sformatf("wd_nopulse_%0d", k), 32'(to[2]), 32'h0);
    end
    step();
    chk("wd_revoke_gp", 32'(gp[2]), 32'h02);
    chk("wd_pulse", 32'(to[2]), 32'h1);
    chk("wd_new_owner", 32'(own[2]), 32'd1);
    step();
    chk("wd_pulse_end", 32'(to[2]), 32'h0);
    req_proc = 8'h01;
    step();
    chk("wd_masked_idle", 32'(gp[2]), 32'h00);
    step();
    chk("wd_still_masked", 32'(gp[2]), 32'h00);
    req_proc = 8'h00;
    step();
    req_proc = 8'h01;
    step();
    chk("wd_regrant0", 32'(gp[2]), 32'h01);

    // Self-snoop error, then asynchronous reset mid-grant
    do_reset();
    req_proc = 8'h08;
    step();
    chk("self_owner3", 32'(gp[0]), 32'h08);
    req_snoop = 8'h08;
    step();
    chk("self_no_gnt", 32'(gs[0]), 32'h00);
    chk("self_err", 32'(err[0]), 32'h1);
    req_snoop = 8'h00;
    step();
    chk("self_err_sticky", 32'(err[0]), 32'h1);
    async_reset_check();

    // Randomized traffic against the model
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 5) == 0) req_proc[b] = ~req_proc[b];
        if ($urandom_range(0, 11) == 0) req_snoop[b] = ~req_snoop[b];
      end
      if ($urandom_range(0, 7) == 0) mem_req = ~mem_req;
      if ($urandom_range(0, 399) == 0) async_reset_check();
      else step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
